// File: rtl/req_debounce4.sv
// req_debounce4: synchronizes and debounces four raw request lines (a..d),
// captures rising (press) events as pending bits and presents them one at a
// time, highest priority first (a > b > c > d), as a registered one-hot word
// with a valid/ready handshake toward the 4-to-2 encoder.
//
// Optional build macro REQ_DEBOUNCE4_STICKY_ERR_EN: when defined, err is a
// sticky flag raised by simultaneous events or by an event on a bit that is
// already pending. When undefined, err is tied low.
module req_debounce4 #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       ready,
    output logic [3:0] oh,
    output logic       valid,
    output logic       err
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic {StIdle, StHold} state_e;

    logic [3:0]       raw;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       deb_q;
    logic [3:0]       deb_prev_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [3:0]       rise;
    logic [3:0]       pend_q;
    logic [3:0]       pick;
    logic [3:0]       take;
    state_e           state_q;

    // Bit 3 is the highest-priority line.
    assign raw  = {a, b, c, d};
    assign rise = deb_q & ~deb_prev_q;

    // Two-flop synchronizer per line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the level follows the synced input only after it differs for DEB_CYCLES edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_prev_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == CntMax) begin
                        deb_q[i] <= sync2_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CntOne;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // Highest-priority pending bit, and whether the FSM consumes it this cycle.
    always_comb begin
        pick = '0;
        if (pend_q[3]) begin
            pick = 4'b1000;
        end else if (pend_q[2]) begin
            pick = 4'b0100;
        end else if (pend_q[1]) begin
            pick = 4'b0010;
        end else if (pend_q[0]) begin
            pick = 4'b0001;
        end
        take = (state_q == StIdle || ready) ? pick : 4'b0000;
    end

    // Pending events; a new rise on a bit being taken this cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~take) | rise;
        end
    end

    // Output FSM: registered one-hot word with back-to-back delivery under ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            oh      <= '0;
            valid   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick != 4'b0000) begin
                        oh      <= pick;
                        valid   <= 1'b1;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (ready) begin
                        if (pick != 4'b0000) begin
                            oh <= pick;
                        end else begin
                            oh      <= '0;
                            valid   <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef REQ_DEBOUNCE4_STICKY_ERR_EN
    logic multi_rise;
    logic err_q;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign multi_rise = (rise & (rise - 4'd1)) != 4'd0;

    // Sticky error on simultaneous events or on an event merged into a pending bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (multi_rise || ((rise & pend_q) != 4'd0)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
